// File: rtl/mc_controller_hs.sv
// mc_controller_hs: multicycle MIPS control FSM with a variable-latency memory handshake, bus timeout
// and precise exceptions through one EXC state. Define MC_CTRL_PERF_EN to add retire/stall counters.
module mc_controller_hs #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8,
  parameter int CAUSE_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               Overflow,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic               PCorData,
  output logic [1:0]         RegDst,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [3:0]         ALUOp,
  output logic               ExcWrite,
  output logic [CAUSE_W-1:0] ExcCause,
`ifdef MC_CTRL_PERF_EN
  output logic [31:0]        instr_retired,
  output logic [31:0]        stall_cycles,
`endif
  output logic [3:0]         state_dbg
);

  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EX     = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_WB_LW  = 4'd4;
  localparam logic [3:0] S_MEM_WR = 4'd5;
  localparam logic [3:0] S_WB_R   = 4'd6;
  localparam logic [3:0] S_JR     = 4'd7;
  localparam logic [3:0] S_EXC    = 4'd8;

  logic [3:0]         state, next_state;
  logic [TO_W-1:0]    to_cnt;
  logic [CAUSE_W-1:0] cause_q;
  logic [1:0]         exc_code;
  logic [2:0]         alu_lo;
  logic               r_type, legal, shift_op, ovf_inst, mem_state, waiting, timed_out;

  // Memory handshake: IF/MEM_RD/MEM_WR hold their request asserted every cycle until mem_ready
  // is seen high; the access completes in that cycle. No ready within MEM_TIMEOUT cycles is a bus error.
  assign r_type    = (OpCode == 6'h00);
  assign shift_op  = r_type && (Funct == 6'h00 || Funct == 6'h02 || Funct == 6'h03);
  assign ovf_inst  = (r_type && (Funct == 6'h20 || Funct == 6'h22)) || (OpCode == 6'h08);
  assign mem_state = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign waiting   = mem_state && !mem_ready;
  assign timed_out = waiting && (to_cnt == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    legal = 1'b0;
    if (r_type) begin
      case (Funct)
        6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21, 6'h22,
        6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end else begin
      case (OpCode)
        6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a, 6'h0b,
        6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: legal = 1'b1;
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    IRWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; PCorData = 1'b0; ExcWrite = 1'b0;
    RegDst = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00;
    ExcCause = '0;
    next_state = state;
    exc_code = 2'b00;
    ExtOp = (OpCode != 6'h0c);
    LuiOp = (OpCode == 6'h0f);
    case (OpCode)
      6'h00:        alu_lo = 3'b010;
      6'h04:        alu_lo = 3'b001;
      6'h0c:        alu_lo = 3'b100;
      6'h0a, 6'h0b: alu_lo = 3'b101;
      6'h09:        alu_lo = 3'b011;
      default:      alu_lo = 3'b000;
    endcase
    ALUOp = {OpCode[0], (state == S_IF || state == S_ID) ? 3'b000 : alu_lo};
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          next_state = S_ID;
        end else if (timed_out) begin
          next_state = S_EXC;
          exc_code = 2'b11;
        end
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        if (legal) next_state = S_EX;
        else begin
          next_state = S_EXC;
          exc_code = 2'b01;
        end
      end
      S_EX: begin
        if (r_type) begin
          ALUSrcA = shift_op ? 2'b10 : 2'b01;
        end else if (OpCode == 6'h04) begin
          ALUSrcA = 2'b01;
          PCWriteCond = 1'b1;
          PCSource = 2'b01;
        end else if (OpCode == 6'h02 || OpCode == 6'h03) begin
          PCWrite = 1'b1;
          PCSource = 2'b11;
          if (OpCode == 6'h03) begin
            RegWrite = 1'b1;
            RegDst = 2'b10;
            PCorData = 1'b1;
          end
        end else begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
        end
        if (r_type && (Funct == 6'h08 || Funct == 6'h09)) next_state = S_JR;
        else if (OpCode == 6'h23) next_state = S_MEM_RD;
        else if (OpCode == 6'h2b) next_state = S_MEM_WR;
        else if (OpCode == 6'h02 || OpCode == 6'h03 || OpCode == 6'h04) next_state = S_IF;
        else next_state = S_WB_R;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        if (mem_ready) next_state = S_WB_LW;
        else if (timed_out) begin
          next_state = S_EXC;
          exc_code = 2'b11;
        end
      end
      S_WB_LW: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        next_state = S_IF;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        if (mem_ready) next_state = S_IF;
        else if (timed_out) begin
          next_state = S_EXC;
          exc_code = 2'b11;
        end
      end
      S_WB_R: begin
        RegDst = r_type ? 2'b01 : 2'b00;
        // Overflowing add/sub/addi must not commit, keeping the exception precise.
        if (Overflow && ovf_inst) begin
          next_state = S_EXC;
          exc_code = 2'b10;
        end else begin
          RegWrite = 1'b1;
          next_state = S_IF;
        end
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSource = 2'b01;
        if (Funct == 6'h09) begin
          RegWrite = 1'b1;
          RegDst = 2'b01;
          PCorData = 1'b1;
        end
        next_state = S_IF;
      end
      S_EXC: begin
        PCWrite = 1'b1;
        PCSource = 2'b10;
        ExcWrite = 1'b1;
        ExcCause = cause_q;
        next_state = S_IF;
      end
      default: next_state = S_IF;
    endcase
    state_dbg = state;
    if (reset) begin
      PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
      IRWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; PCorData = 1'b0; ExcWrite = 1'b0;
      RegDst = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00;
      ExcCause = '0; ExtOp = 1'b0; LuiOp = 1'b0; ALUOp = 4'b0000; state_dbg = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      to_cnt  <= '0;
      cause_q <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) to_cnt <= '0;
      else if (waiting) to_cnt <= to_cnt + TO_W'(1);
      if (next_state == S_EXC && state != S_EXC) cause_q <= CAUSE_W'(exc_code);
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_cnt, stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (next_state == S_IF && state != S_IF && state != S_EXC) instr_cnt <= instr_cnt + 32'd1;
      if (waiting) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign instr_retired = reset ? 32'd0 : instr_cnt;
  assign stall_cycles  = reset ? 32'd0 : stall_cnt;
`endif

endmodule
